// File: rtl/fetch_mem_responder_if.sv
// rtl/fetch_mem_responder_if.sv - program-memory fetch/load bus between core (master) and responder (slave)
interface fetch_mem_responder_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ack;
  logic [7:0]        fetch_count;

  modport master (
    output load_en, load_addr, load_data, fetch_req, fetch_addr, rsp_ack,
    input  fetch_ready, rsp_valid, rsp_data, fetch_count
  );

  modport slave (
    input  load_en, load_addr, load_data, fetch_req, fetch_addr, rsp_ack,
    output fetch_ready, rsp_valid, rsp_data, fetch_count
  );
endinterface

// File: rtl/fetch_mem_responder.sv
// rtl/fetch_mem_responder.sv - 16-entry instruction store answering one fetch at a time after LATENCY cycles
module fetch_mem_responder #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_mem_responder_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              fetch_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [7:0]        fetch_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.load_en) begin
      mem_q[bus.load_addr] <= bus.load_data;
    end
  end

  // rsp_valid is registered off the RESP state, so it rises one edge after
  // RESP is entered; that extra edge makes accept-to-valid equal LATENCY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hold_q        <= '0;
      fetch_ready_q <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.fetch_req && fetch_ready_q) begin
            hold_q        <= mem_q[bus.fetch_addr];
            fetch_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= RESP;
          end
        end
        RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= hold_q;
          end else if (bus.rsp_ack) begin
            state_q       <= IDLE;
            rsp_valid_q   <= 1'b0;
            fetch_ready_q <= 1'b1;
            fetch_count_q <= fetch_count_q + 8'd1;
          end
        end
        default: begin
          state_q       <= IDLE;
          fetch_ready_q <= 1'b1;
          rsp_valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fetch_ready = fetch_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.fetch_count = fetch_count_q;
endmodule

// File: doc/fetch_mem_responder.md
Name: fetch_mem_responder

Overview:
- Instruction-memory responder that serves instruction fetches issued by the FDE core (the fetch side of the core's program-memory interface).
- Holds a 16-entry instruction store, written through a load port by the bench or program loader.
- Accepts one fetch at a time and returns the instruction word after a fixed latency.
- Holds the response until the core acknowledges it.
- Instruction word layout: opcode[15:12], srcadd_1[11:8], srcadd_2[7:4], dstadd[3:0].

Parameters:
- ADDR_W, 4, address width (matches 4-bit pc); depth = 2**ADDR_W.
- DATA_W, 16, instruction word width.
- LATENCY, 2, cycles from fetch accept to rsp_valid; legal range 1..7.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- load_en  input  1  write strobe for the instruction store.
- load_addr  input  ADDR_W  write address.
- load_data  input  DATA_W  write data.
- fetch_req  input  1  core requests an instruction.
- fetch_addr  input  ADDR_W  fetch address (pc).
- fetch_ready  output  1  responder can accept a fetch this cycle.
- rsp_valid  output  1  rsp_data holds a valid instruction.
- rsp_data  output  DATA_W  fetched instruction word.
- rsp_ack  input  1  core consumes the response.
- fetch_count  output  8  number of completed responses, wraps 255->0.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE, fetch_ready=1, rsp_valid=0, rsp_data=0, fetch_count=0;
  - latency counter=0;
  - all store entries=0 (0x0000 is a NOP).
- A reset asserted mid-operation drops any pending or held response immediately. No response is produced after reset releases.
- Store write: on a rising edge with load_en=1, mem[load_addr]<=load_data. Writes are legal in every state.
- Fetch accept occurs on a rising edge where fetch_req=1 and fetch_ready=1. At accept, the word mem[fetch_addr] is captured into an internal holding register.
- Same-edge load to the same address as an accepted fetch: the store is updated, but the response carries the OLD word (read-before-write).
- State machine:
  - IDLE: fetch_ready=1, rsp_valid=0.
    - On accept with LATENCY=1, go to RESP.
    - On accept with LATENCY>1, go to WAIT with counter=LATENCY-1.
  - WAIT: fetch_ready=0, rsp_valid=0.
    - Counter decrements every cycle.
    - When counter==1 at an edge, go to RESP.
    - fetch_req is ignored here and no request is queued.
  - RESP: fetch_ready=0, rsp_valid=1, rsp_data=captured word, held stable until acknowledged.
    - On an edge with rsp_ack=1: go to IDLE, fetch_count<=fetch_count+1 (mod 256), rsp_valid deasserts, rsp_data keeps its last value.
    - rsp_ack while not in RESP is ignored.
- Latency: accept at edge N puts rsp_valid=1 after edge N+LATENCY.
- Throughput: a new accept is possible at the earliest on the edge after the ack edge, so at most one fetch per LATENCY+2 cycles.
- The core's stop signal is not an input. A stalled core simply leaves rsp_ack low, and the responder holds RESP indefinitely.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset then load: assert reset, release it, write mem[3]=0x1A2B. Fetch addr 3 with LATENCY=2, accept at edge N -> rsp_valid=1 after edge N+2 with rsp_data=0x1A2B. Ack -> fetch_count=1 and fetch_ready=1 on the next cycle.
- Hold under stall: fetch addr 5 (containing 0x4321) and keep rsp_ack=0 for 10 cycles -> rsp_valid stays 1 and rsp_data stays 0x4321 throughout. Meanwhile hold fetch_req=1 with addr 6 -> fetch_ready=0 and nothing is accepted.
- Read-before-write: mem[2]=0x1111; on the same edge accept a fetch of addr 2 and load mem[2]=0x2222 -> the response is 0x1111. A second fetch of addr 2 returns 0x2222.
- Sequential program: load mem[0..15]=16'h0000+i*16'h1111 (truncated) and fetch pc 0..15 then 0 again, acking each response -> each rsp_data matches its entry. pc wrap-around returns mem[0]. fetch_count=17.
- Reset mid-operation: accept a fetch and assert reset during WAIT -> rsp_valid=0, fetch_ready=1, fetch_count=0, mem all 0. After release, no stray rsp_valid appears; a fetch of any address returns 0x0000.
- Counter wrap plus LATENCY=1 build: perform 256 fetch/ack pairs -> fetch_count goes 255->0. In the LATENCY=1 build, rsp_valid rises exactly one edge after accept.
